// File: rtl/sa_tile_ctrl.sv
// sa_tile_ctrl: tile-pass sequencer for a ROWS x COLS systolic array (operand reads, skewed row strobes, drain, handshake).
// Define SA_TILE_CTRL_PERF_EN to add the perf_cycles busy-cycle counter port.
module sa_tile_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  input  logic [K_W-1:0]    k_len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic              stall,
  input  logic              abort,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              acc_clr,
  output logic [ROWS-1:0]   row_vld,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
`ifdef SA_TILE_CTRL_PERF_EN
  , output logic [31:0]     perf_cycles
`endif
);
  localparam logic [1:0] IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2, OUT = 2'd3;
  localparam int DN = ROWS + COLS - 1;
  localparam int DW = $clog2(DN + 1);
  logic [1:0]        state;
  logic [K_W-1:0]    k_q, k_cnt;
  logic [ADDR_W-1:0] a_q, w_q;
  logic [DW-1:0]     d_cnt;
  logic [ROWS-1:0]   sr;
  logic              first_q, hold, rd;
  assign hold      = stall & (state == FEED | state == DRAIN);
  assign rd        = state == FEED & ~stall;
  assign ready     = state == IDLE;
  assign busy      = ~ready;
  assign a_rd_en   = rd;
  assign w_rd_en   = rd;
  assign a_rd_addr = rd ? a_q + ADDR_W'(k_cnt) : '0;
  assign w_rd_addr = rd ? w_q + ADDR_W'(k_cnt) : '0;
  // a stalled cycle freezes the skew line, so nothing may accumulate in it
  assign row_vld   = hold ? '0 : sr;
  assign acc_clr   = first_q & sr[0] & ~hold;
  assign out_valid = state == OUT;
  assign done      = out_valid & out_ready & ~abort;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k_q     <= '0;
      k_cnt   <= '0;
      a_q     <= '0;
      w_q     <= '0;
      d_cnt   <= '0;
      sr      <= '0;
      first_q <= 1'b0;
    end else if (abort && state != IDLE) begin
      state   <= IDLE;
      k_cnt   <= '0;
      d_cnt   <= '0;
      sr      <= '0;
      first_q <= 1'b0;
    end else begin
      if (!hold) sr <= {sr[ROWS-2:0], rd};
      if (acc_clr) first_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          k_q     <= k_len;
          a_q     <= a_base;
          w_q     <= w_base;
          k_cnt   <= '0;
          d_cnt   <= '0;
          first_q <= k_len != '0;
          state   <= k_len == '0 ? OUT : FEED;
        end
        FEED: if (!stall) begin
          k_cnt <= k_cnt == k_q - K_W'(1) ? '0 : k_cnt + K_W'(1);
          state <= k_cnt == k_q - K_W'(1) ? DRAIN : FEED;
        end
        DRAIN: if (!stall) begin
          d_cnt <= d_cnt == DW'(DN - 1) ? '0 : d_cnt + DW'(1);
          state <= d_cnt == DW'(DN - 1) ? OUT : DRAIN;
        end
        OUT: if (out_ready) state <= IDLE;
      endcase
    end
  end
`ifdef SA_TILE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_cycles <= '0;
    else if (ready && start) perf_cycles <= '0;
    else if (busy) perf_cycles <= perf_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_sa_tile_ctrl.sv
// tb_sa_tile_ctrl: randomized + directed bench for sa_tile_ctrl against a step-count tile model.
module tb_sa_tile_ctrl;
  localparam int ROWS = 4, COLS = 4, K_W = 8, ADDR_W = 10, D = ROWS + COLS - 1;
  logic clk = 0, rst_n = 0, start = 0, stall = 0, abort = 0, out_ready = 0;
  logic [K_W-1:0] k_len = '0;
  logic [ADDR_W-1:0] a_base = '0, w_base = '0;
  logic ready, a_rd_en, w_rd_en, acc_clr, busy, out_valid, done;
  logic [ADDR_W-1:0] a_rd_addr, w_rd_addr;
  logic [ROWS-1:0] row_vld;
`ifdef SA_TILE_CTRL_PERF_EN
  logic [31:0] perf_cycles;
  int e_perf;
`endif
  sa_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .k_len(k_len),
    .a_base(a_base), .w_base(w_base), .stall(stall), .abort(abort),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .acc_clr(acc_clr), .row_vld(row_vld), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
`ifdef SA_TILE_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  // tile model: n counts unstalled FEED/DRAIN cycles since accept
  bit act = 0;
  int n = 0, kk = 0, ab_m = 0, wb_m = 0, perf_m = 0;
  logic e_ready, e_rd, e_acc, e_ov, e_done;
  logic [ADDR_W-1:0] e_a, e_w;
  logic [ROWS-1:0] e_row;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic cycle();
    bit outp, hold;
    @(negedge clk);
    if (!rst_n) begin
      act = 0;
      perf_m = 0;
    end
    outp = act && (kk == 0 || n >= kk + D);
    hold = act && !outp && stall;
    e_ready = !act;
    e_rd = act && n < kk && !stall;
    e_a = e_rd ? ADDR_W'(ab_m + n) : '0;
    e_w = e_rd ? ADDR_W'(wb_m + n) : '0;
    for (int r = 0; r < ROWS; r++) e_row[r] = act && !hold && n >= r + 1 && n - 1 - r < kk;
    e_acc = act && !hold && kk > 0 && n == 1;
    e_ov = outp;
    e_done = outp && out_ready && !abort;
    chk("ready", ready, e_ready);
    chk("busy", busy, !e_ready);
    chk("a_rd_en", a_rd_en, e_rd);
    chk("w_rd_en", w_rd_en, e_rd);
    chk("a_rd_addr", a_rd_addr, e_a);
    chk("w_rd_addr", w_rd_addr, e_w);
    chk("acc_clr", acc_clr, e_acc);
    chk("row_vld", row_vld, e_row);
    chk("out_valid", out_valid, e_ov);
    chk("done", done, e_done);
`ifdef SA_TILE_CTRL_PERF_EN
    e_perf = perf_m;
    chk("perf_cycles", perf_cycles, perf_m);
`endif
    @(posedge clk);
    if (rst_n) begin
      if (!act) begin
        if (start) begin
          act = 1; n = 0; kk = k_len; ab_m = a_base; wb_m = w_base; perf_m = 0;
        end
      end else begin
        perf_m++;
        if (abort) act = 0;
        else if (outp) begin
          if (out_ready) act = 0;
        end else if (!stall) n++;
      end
    end
    #1;
  endtask
  task automatic step(input logic s, input int kl, input int a, input int w,
                      input logic st, input logic ab, input logic ordy);
    start = s; k_len = K_W'(kl); a_base = ADDR_W'(a); w_base = ADDR_W'(w);
    stall = st; abort = ab; out_ready = ordy;
    cycle();
  endtask
  task automatic go_idle();
    int t = 0;
    while (!ready && t < 400) begin
      step(0, 0, 0, 0, 0, 0, 1);
      t++;
    end
    chk("idle_reach", ready, 1);
  endtask
  initial begin
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    step(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 14; c++) begin
      step(c == 0, 3, 'h010, 'h200, 0, 0, c == 12);
      if (c == 1) chk("t1_rd_first", e_rd, 1);
      if (c == 2) chk("t1_acc_clr", e_acc, 1);
      if (c == 3) chk("t1_a_addr_last", e_a, 'h012);
      if (c == 3) chk("t1_w_addr_last", e_w, 'h202);
      if (c == 4) chk("t1_rd_off", e_rd, 0);
      if (c == 7) chk("t1_row3_last", e_row, 4'b1000);
      if (c == 10) chk("t1_not_out", e_ov, 0);
      if (c == 11) chk("t1_out_valid", e_ov, 1);
      if (c == 12) chk("t1_done", e_done, 1);
      if (c == 13) chk("t1_ready", e_ready, 1);
    end
    for (int c = 0; c < 15; c++) begin
      step(c == 0, 3, 'h010, 'h200, c == 2, 0, c == 13);
      if (c == 2) chk("t2_row_stall", e_row, 0);
      if (c == 2) chk("t2_rd_stall", e_rd, 0);
      if (c == 3) chk("t2_reissue", e_a, 'h011);
      if (c == 3) chk("t2_acc_clr", e_acc, 1);
      if (c == 12) chk("t2_out_valid", e_ov, 1);
      if (c == 13) chk("t2_done", e_done, 1);
    end
    for (int c = 0; c < 4; c++) begin
      step(c == 0, 0, 5, 5, 0, 0, c == 2);
      if (c == 1) chk("t3_ready_low", e_ready, 0);
      if (c == 1) chk("t3_out_valid", e_ov, 1);
      if (c == 2) chk("t3_done", e_done, 1);
    end
    for (int c = 0; c < 14; c++) begin
      step(c == 0, 4, 'h3FE, 'h100, 0, 0, c == 12);
      if (c == 2) chk("t4_addr_3ff", e_a, 'h3FF);
      if (c == 3) chk("t4_addr_wrap", e_a, 'h000);
      if (c == 4) chk("t4_addr_001", e_a, 'h001);
      if (c == 12) chk("t4_done", e_done, 1);
    end
    for (int c = 0; c < 22; c++) begin
      step(c == 0 || c == 8, 3, 'h010, 'h200, 0, c == 6, c == 20);
      if (c == 6) chk("t5_no_done", e_done, 0);
      if (c == 7) chk("t5_idle", e_ready, 1);
      if (c == 7) chk("t5_row_clr", e_row, 0);
      if (c == 9) chk("t5_restart", e_rd, 1);
      if (c == 19) chk("t5_out_valid", e_ov, 1);
    end
    go_idle();
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst_n = 0;
      step(c == 0, 3, 'h010, 'h200, 0, 0, 0);
      if (c >= 2) chk("t6_rst_ready", e_ready, 1);
    end
    rst_n = 1;
    for (int c = 0; c < 14; c++) begin
      step(c == 0, 3, 'h010, 'h200, 0, 0, c == 12);
      if (c == 12) chk("t6_done", e_done, 1);
`ifdef SA_TILE_CTRL_PERF_EN
      if (c == 13) chk("t6_perf", e_perf, 12);
`endif
    end
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(999) == 0) rst_n = 0;
      step($urandom_range(3) == 0,
           $urandom_range(9) == 0 ? $urandom_range(255) : $urandom_range(5),
           $urandom_range(1023), $urandom_range(1023),
           $urandom_range(4) == 0, $urandom_range(59) == 0, $urandom_range(1) == 1);
      rst_n = 1;
    end
    go_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
